// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The master drives the write/read requests and the slave is the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, overflow/underflow pulses and a registered-read or first-word-fall-through
// output. All flags are registered from the next count value, so they always agree
// with count and have no combinational path from the request inputs.
module sync_fifo_flags #(
  parameter int WIDTH     = 24,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 8,
  parameter int AE_THRESH = 8,
  parameter int FWFT      = 0
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flags_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_T  = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_T  = (AW+1)'(AE_THRESH);
  localparam logic [AW:0] FULL_T = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt;
  logic             empty_r;
  logic             full_r;
  logic             af_r;
  logic             ae_r;
  logic             ovf_r;
  logic             udf_r;
  logic             wr_acc;
  logic             rd_acc;

  // A write is refused whenever full, even if a read frees a slot this cycle.
  assign wr_acc = bus.wr_en && !full_r;
  assign rd_acc = bus.rd_en && !empty_r;

  // Next occupancy: simultaneous accepted write and read leave it unchanged.
  always_comb begin
    count_nxt = count_r;
    if (wr_acc && !rd_acc)
      count_nxt = count_r + (AW+1)'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count_r - (AW+1)'(1);
  end

  // Pointers, count, flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      af_r    <= (AF_THRESH == 0);
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count_r <= count_nxt;
      empty_r <= (count_nxt == '0);
      full_r  <= (count_nxt == FULL_T);
      af_r    <= (count_nxt >= AF_T);
      ae_r    <= (count_nxt <= AE_T);
      ovf_r   <= bus.wr_en && full_r;
      udf_r   <= bus.rd_en && empty_r;
    end
  end

  // Storage write; contents survive reset, and requests during reset are ignored.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc)
      mem[wr_ptr] <= bus.din;
  end

  assign bus.count        = count_r;
  assign bus.empty        = empty_r;
  assign bus.full         = full_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly from storage while the FIFO holds data.
    assign bus.dout  = mem[rd_ptr];
    assign bus.valid = !empty_r;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_p1;
    logic             vld_p1;

    // Stage p1: registered read; dout holds its value between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= rd_acc;
        if (rd_acc) dout_p1 <= mem[rd_ptr];
      end
    end

    assign bus.dout  = dout_p1;
    assign bus.valid = vld_p1;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: three configurations (default registered-read,
// first-word-fall-through, small FIFO with tight thresholds) checked cycle by cycle
// against a queue-based reference model.
module tb_sync_fifo_flags;
  logic clk;
  logic rst_a, rst_b, rst_c;

  sync_fifo_flags_if #(.WIDTH(24), .DEPTH(64)) if_a ();
  sync_fifo_flags_if #(.WIDTH(24), .DEPTH(64)) if_b ();
  sync_fifo_flags_if #(.WIDTH(8),  .DEPTH(8))  if_c ();

  sync_fifo_flags #(.WIDTH(24), .DEPTH(64), .AF_THRESH(56), .AE_THRESH(8), .FWFT(0))
    u_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
  sync_fifo_flags #(.WIDTH(24), .DEPTH(64), .AF_THRESH(56), .AE_THRESH(8), .FWFT(1))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stepno = 0;
  int sel    = 0;

  // Reference model: contents as a queue, flags derived from its size.
  logic [23:0] q[$];
  int          m_depth, m_af, m_ae;
  bit          m_fwft;
  logic [23:0] mask;
  logic [23:0] e_dout;
  logic        e_valid, e_ovf, e_udf;

  logic [23:0] o_dout;
  logic        o_valid, o_empty, o_full, o_af, o_ae, o_ovf, o_udf;
  logic [31:0] o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic re, input logic [23:0] d);
    case (sel)
      0: begin rst_a = r; if_a.wr_en = w; if_a.rd_en = re; if_a.din = d; end
      1: begin rst_b = r; if_b.wr_en = w; if_b.rd_en = re; if_b.din = d; end
      default: begin rst_c = r; if_c.wr_en = w; if_c.rd_en = re; if_c.din = d[7:0]; end
    endcase
  endtask

  task automatic sample();
    case (sel)
      0: begin
        o_dout = if_a.dout; o_valid = if_a.valid; o_empty = if_a.empty; o_full = if_a.full;
        o_af = if_a.almost_full; o_ae = if_a.almost_empty; o_cnt = 32'(if_a.count);
        o_ovf = if_a.overflow; o_udf = if_a.underflow;
      end
      1: begin
        o_dout = if_b.dout; o_valid = if_b.valid; o_empty = if_b.empty; o_full = if_b.full;
        o_af = if_b.almost_full; o_ae = if_b.almost_empty; o_cnt = 32'(if_b.count);
        o_ovf = if_b.overflow; o_udf = if_b.underflow;
      end
      default: begin
        o_dout = 24'(if_c.dout); o_valid = if_c.valid; o_empty = if_c.empty; o_full = if_c.full;
        o_af = if_c.almost_full; o_ae = if_c.almost_empty; o_cnt = 32'(if_c.count);
        o_ovf = if_c.overflow; o_udf = if_c.underflow;
      end
    endcase
  endtask

  // One clock cycle: apply inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic w, input logic re, input logic [23:0] d);
    logic [23:0] popped;
    bit full_b, empty_b;
    int n;
    @(negedge clk);
    drive(r, w, re, d);
    if (r) begin
      q.delete();
      e_dout = '0; e_valid = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
    end else begin
      full_b  = (q.size() == m_depth);
      empty_b = (q.size() == 0);
      e_ovf   = w && full_b;
      e_udf   = re && empty_b;
      e_valid = 1'b0;
      if (re && !empty_b) begin
        popped = q.pop_front();
        if (!m_fwft) begin e_dout = popped; e_valid = 1'b1; end
      end
      if (w && !full_b) q.push_back(d & mask);
    end
    @(posedge clk);
    #1;
    stepno++;
    sample();
    n = q.size();
    chk("count", o_cnt, 32'(n));
    chk("empty", 32'(o_empty), 32'(n == 0));
    chk("full", 32'(o_full), 32'(n == m_depth));
    chk("almost_full", 32'(o_af), 32'(n >= m_af));
    chk("almost_empty", 32'(o_ae), 32'(n <= m_ae));
    chk("overflow", 32'(o_ovf), 32'(e_ovf));
    chk("underflow", 32'(o_udf), 32'(e_udf));
    if (m_fwft) begin
      chk("valid", 32'(o_valid), 32'(n != 0));
      if (n != 0) chk("dout_fwft", 32'(o_dout), 32'(q[0]));
    end else begin
      chk("valid", 32'(o_valid), 32'(e_valid));
      chk("dout", 32'(o_dout), 32'(e_dout));
    end
  endtask

  task automatic rand_steps(input int n, input int pw, input int pr);
    for (int i = 0; i < n; i++)
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 99) < pw),
           ($urandom_range(0, 99) < pr), 24'($urandom));
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.wr_en = 1'b0; if_a.rd_en = 1'b0; if_a.din = '0;
    if_b.wr_en = 1'b0; if_b.rd_en = 1'b0; if_b.din = '0;
    if_c.wr_en = 1'b0; if_c.rd_en = 1'b0; if_c.din = '0;

    // Configuration A: DEPTH 64, registered read.
    sel = 0; m_depth = 64; m_af = 56; m_ae = 8; m_fwft = 0; mask = 24'hFFFFFF;
    step(1, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 1, 0, 24'(i));
    step(0, 1, 0, 24'h000099);
    step(0, 1, 1, 24'h000077);
    for (int i = 0; i < 63; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 24'(100 + i));
    for (int i = 0; i < 200; i++) step(0, 1, 1, 24'(1000 + i));
    for (int i = 0; i < 27; i++) step(0, 1, 0, 24'(2000 + i));
    step(1, 1, 1, 24'h000005);
    step(0, 1, 0, 24'h5A5A5A);
    step(0, 0, 1, 0);
    rand_steps(300, 60, 40);
    rand_steps(300, 40, 60);
    step(0, 0, 0, 0);

    // Configuration B: DEPTH 64, first-word-fall-through.
    sel = 1; m_depth = 64; m_af = 56; m_ae = 8; m_fwft = 1; mask = 24'hFFFFFF;
    step(1, 0, 0, 0);
    step(0, 1, 0, 24'hABCDEF);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    rand_steps(300, 55, 45);
    step(0, 0, 0, 0);

    // Configuration C: DEPTH 8, AF 4, AE 1, WIDTH 8.
    sel = 2; m_depth = 8; m_af = 4; m_ae = 1; m_fwft = 0; mask = 24'h0000FF;
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 24'(8'hA0 + i));
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    rand_steps(400, 50, 50);
    step(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
